input_conditioner: RTL and testbench
====================================

Name: input_conditioner

Overview:
- Per-bit input conditioning stage between the board switches/keys and the landing-lights FSM.
- Each bit passes through a two-flop synchronizer, then a consecutive-sample debounce filter.
- Outputs a clean level per bit, plus single-cycle rise/fall pulses.
- The top level routes conditioned SW[1:0] into the FSM instead of raw SW; KEY polarity inversion stays at the top level.

Parameters:
- WIDTH, 2, number of independent input bits conditioned.
- DEBOUNCE_CYCLES, 4, consecutive cycles the synchronized input must differ from clean before clean follows it; legal range 1..65535.

Ports:
- clk  input  1  single system clock (divided board clock or CLOCK_50 in simulation).
- reset  input  1  asynchronous, active-high reset.
- raw  input  WIDTH  unsynchronized switch/key levels (already active-high).
- clean  output  WIDTH  debounced, synchronized level.
- rise  output  WIDTH  one-cycle pulse when clean[i] goes 0->1.
- fall  output  WIDTH  one-cycle pulse when clean[i] goes 1->0.
- changed  output  1  OR of all rise and fall bits, same cycle.

Behaviour:
- Reset (async assert, sync release): sync1, sync2, clean, rise, fall, changed and all counters = 0.
- All bits are fully independent; no cross-bit coupling except `changed`.
- Synchronizer on each clk edge: sync1 <= raw; sync2 <= sync1. No logic between the two flops.
- Counter per bit is $clog2(DEBOUNCE_CYCLES+1) bits wide and never wraps. Evaluated each edge, in priority order:
  - sync2 == clean: cnt <= 0; rise/fall <= 0.
  - else if cnt == DEBOUNCE_CYCLES-1: clean <= sync2; cnt <= 0; rise <= sync2; fall <= ~sync2.
  - else: cnt <= cnt+1; rise/fall <= 0.
- Latency: raw changes before edge E0 and stays stable. Then:
  - sync2 reflects the change after E1.
  - clean updates at edge E(DEBOUNCE_CYCLES+1), with the pulse registered on the same edge.
  - DEBOUNCE_CYCLES=4 gives clean at E5; DEBOUNCE_CYCLES=1 gives clean at E2.
- Glitch rejection: if sync2 returns to clean before the count completes, cnt clears. A sync2 excursion shorter than DEBOUNCE_CYCLES cycles never reaches clean and produces no pulse.
- Pulse width: rise/fall are high for exactly one cycle per clean transition. rise and fall are never high together on one bit.
- Reset mid-count: counter and clean clear immediately; the partial count is discarded.
- Input high across reset release: clean rises normally after DEBOUNCE_CYCLES+2 edges, with a rise pulse. This is intentional, so the FSM sees a defined edge.
- Simultaneous transitions on several bits produce independent pulses on the same cycle; changed is high once.
- No combinational path from raw to any output; all outputs are registered.

Decomposition:
- Shared package (input_cond_pkg):
  - constant DEFAULT_DEBOUNCE_CYCLES = 4.
  - function cnt_width(n) returning $clog2(n+1), used by all debounce instances.
- One sub-module, debounce_bit: single-bit synchronizer + counter + edge pulses, parameterized by DEBOUNCE_CYCLES.
- input_conditioner:
  - generate-instantiates WIDTH copies of debounce_bit.
  - ORs the rise/fall outputs into changed.

Test Plan (WIDTH=2, DEBOUNCE_CYCLES=4):
- Reset, then raw=2'b00 for 10 cycles -> clean=00, rise=fall=00, changed=0 throughout.
- raw[0] 0->1 before E0, held -> clean[0]=1 from E5; rise[0]=1 for exactly the cycle after E5; changed=1 same cycle; clean[1] stays 0.
- raw[1] pulsed high for 3 cycles then low -> clean[1] stays 0; no rise/fall; counter returns to 0.
- raw=11 then raw=00 on the same edge, held -> at E5 clean=00, fall=11 for one cycle, changed=1 for one cycle.
- raw[0]=1 held; reset asserted 2 cycles after the change, released 2 cycles later -> outputs 0 immediately on assert; clean[0]=1 exactly 6 edges after release, with a rise pulse.
- Bounce pattern on raw[0] (1,0,1,1,0,1,1,1,1 per cycle) -> clean[0] rises only after 4 consecutive synchronized 1s; exactly one rise pulse total.

Source files
------------

// File: rtl/input_cond_pkg.sv
// -----------------------------------------------------------------------------
// input_cond_pkg
// Shared constants and helpers for the switch/key input conditioner.
//   DEFAULT_DEBOUNCE_CYCLES : default number of consecutive disagreeing samples
//                             needed before the clean level follows the input.
//   cnt_width(n)            : width of a counter that must hold values 0..n.
// -----------------------------------------------------------------------------
package input_cond_pkg;

  localparam int DEFAULT_DEBOUNCE_CYCLES = 4;

  // Width of a counter able to hold 0..n; every debounce instance sizes its
  // counter with this so all bits agree on the same encoding.
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/debounce_bit.sv
// -----------------------------------------------------------------------------
// debounce_bit
// One input bit: two-flop synchronizer, consecutive-sample debounce counter and
// registered single-cycle edge pulses.
// Ports:
//   clk    : system clock
//   reset  : asynchronous active-high reset
//   raw    : unsynchronized active-high level
//   clean  : debounced, synchronized level
//   rise   : one-cycle pulse when clean goes 0->1
//   fall   : one-cycle pulse when clean goes 1->0
// DEBOUNCE_CYCLES is legal in the range 1..65535.
// -----------------------------------------------------------------------------
module debounce_bit
  import input_cond_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic clean,
  output logic rise,
  output logic fall
);

  localparam int              CW   = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]   LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_clean;
  logic          r_rise;
  logic          r_fall;
  logic [CW-1:0] r_cnt;

  // Synchronizer: nothing may sit between the two flops so the first one has a
  // full cycle to resolve metastability.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= raw;
      r_sync2 <= r_sync1;
    end
  end

  // Debounce: the counter tracks how many consecutive samples have disagreed
  // with clean. Any agreeing sample discards the partial count, so a short
  // excursion never reaches clean. The counter saturates at LAST and resets
  // on the update, so it can never wrap.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_clean <= 1'b0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
      r_cnt   <= '0;
    end else if (r_sync2 == r_clean) begin
      r_cnt   <= '0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
    end else if (r_cnt == LAST) begin
      r_clean <= r_sync2;
      r_cnt   <= '0;
      r_rise  <= r_sync2;
      r_fall  <= ~r_sync2;
    end else begin
      r_cnt   <= r_cnt + 1'b1;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
    end
  end

  assign clean = r_clean;
  assign rise  = r_rise;
  assign fall  = r_fall;

endmodule

// File: rtl/input_conditioner.sv
// -----------------------------------------------------------------------------
// input_conditioner
// Conditions WIDTH independent switch/key bits before they reach the
// landing-lights FSM. Each bit is synchronized and debounced separately.
// Ports:
//   clk     : system clock
//   reset   : asynchronous active-high reset
//   raw     : [WIDTH-1:0] unsynchronized active-high levels
//   clean   : [WIDTH-1:0] debounced levels
//   rise    : [WIDTH-1:0] one-cycle 0->1 pulses of clean
//   fall    : [WIDTH-1:0] one-cycle 1->0 pulses of clean
//   changed : high whenever any rise or fall bit is high
// -----------------------------------------------------------------------------
module input_conditioner
  import input_cond_pkg::*;
#(
  parameter int WIDTH           = 2,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] raw,
  output logic [WIDTH-1:0] clean,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic             changed
);

  logic [WIDTH-1:0] w_clean;
  logic [WIDTH-1:0] w_rise;
  logic [WIDTH-1:0] w_fall;

  for (genvar g = 0; g < WIDTH; g++) begin : g_bit
    debounce_bit #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debounce_bit (
      .clk   (clk),
      .reset (reset),
      .raw   (raw[g]),
      .clean (w_clean[g]),
      .rise  (w_rise[g]),
      .fall  (w_fall[g])
    );
  end

  // Only registered pulses feed this OR, so there is still no path from raw
  // to any output.
  assign changed = |{w_rise, w_fall};
  assign clean   = w_clean;
  assign rise    = w_rise;
  assign fall    = w_fall;

endmodule

// File: tb/tb_input_conditioner.sv
module tb_input_conditioner;

  localparam int WIDTH = 2;
  localparam int D     = 4;

  logic             clk;
  logic             reset;
  logic [WIDTH-1:0] raw;
  logic [WIDTH-1:0] clean;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic             changed;

  input_conditioner #(
    .WIDTH           (WIDTH),
    .DEBOUNCE_CYCLES (D)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .raw     (raw),
    .clean   (clean),
    .rise    (rise),
    .fall    (fall),
    .changed (changed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors;
  int miscompares;

  // Reference model: raw samples per edge; the debounced value at edge k looks
  // at the raw sample taken two edges earlier, and clean flips when the last D
  // such samples all disagree with it.
  logic [WIDTH-1:0] rawq[$];
  logic [WIDTH-1:0] sq[$];
  logic [WIDTH-1:0] exp_clean, exp_rise, exp_fall;
  logic             exp_changed;
  logic [6:0]       exp_v;
  wire  [6:0]       obs = {clean, rise, fall, changed};

  task automatic model_reset();
    rawq.delete();
    sq.delete();
    exp_clean   = '0;
    exp_rise    = '0;
    exp_fall    = '0;
    exp_changed = 1'b0;
    exp_v       = '0;
  endtask

  // Drive raw, advance one clock edge, advance the model, and settle #1.
  task automatic step(input logic [WIDTH-1:0] v);
    logic [WIDTH-1:0] s;
    raw = v;
    @(posedge clk);
    rawq.push_back(v);
    s = (rawq.size() >= 3) ? rawq[rawq.size()-3] : '0;
    if (rawq.size() > 3) void'(rawq.pop_front());
    sq.push_back(s);
    if (sq.size() > D) void'(sq.pop_front());
    exp_rise = '0;
    exp_fall = '0;
    for (int b = 0; b < WIDTH; b++) begin
      bit all_diff;
      all_diff = (sq.size() == D);
      foreach (sq[j]) if (sq[j][b] == exp_clean[b]) all_diff = 1'b0;
      if (all_diff) begin
        exp_clean[b] = ~exp_clean[b];
        exp_rise[b]  = exp_clean[b];
        exp_fall[b]  = ~exp_clean[b];
      end
    end
    exp_changed = |{exp_rise, exp_fall};
    exp_v = {exp_clean, exp_rise, exp_fall, exp_changed};
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    raw   = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if (obs !== 7'b0) begin
      miscompares++;
      $display("FAIL reset_state got %b exp %b", obs, 7'b0);
    end
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step(2'b00);
      vectors++;
      if (obs !== exp_v) begin
        miscompares++;
        $display("FAIL idle_zero cyc%0d got %b exp %b", k, obs, exp_v);
      end
    end
  endtask

  task automatic test_rise_latency();
    int first_k = -1;
    int rises   = 0;
    for (int k = 0; k < 10; k++) begin
      step(2'b01);
      vectors++;
      if (obs !== exp_v) begin
        miscompares++;
        $display("FAIL rise_model cyc%0d got %b exp %b", k, obs, exp_v);
      end
      if (clean[0] && first_k < 0) first_k = k;
      if (rise[0]) rises++;
    end
    vectors++;
    if (first_k !== 5) begin
      miscompares++;
      $display("FAIL rise_latency got edge %0d exp edge 5", first_k);
    end
    vectors++;
    if (rises !== 1) begin
      miscompares++;
      $display("FAIL rise_pulse_count got %0d exp 1", rises);
    end
  endtask

  task automatic test_glitch();
    int pulses = 0;
    for (int k = 0; k < 11; k++) begin
      step((k < 3) ? 2'b11 : 2'b01);
      vectors++;
      if (obs !== exp_v) begin
        miscompares++;
        $display("FAIL glitch_model cyc%0d got %b exp %b", k, obs, exp_v);
      end
      if (rise[1] || fall[1] || clean[1]) pulses++;
    end
    vectors++;
    if (pulses !== 0) begin
      miscompares++;
      $display("FAIL glitch_reject got %0d events exp 0", pulses);
    end
  endtask

  task automatic test_simultaneous();
    int first_k = -1;
    int falls   = 0;
    int chg     = 0;
    for (int k = 0; k < 10; k++) step(2'b11);
    vectors++;
    if (clean !== 2'b11) begin
      miscompares++;
      $display("FAIL simul_settle got %b exp 11", clean);
    end
    for (int k = 0; k < 10; k++) begin
      step(2'b00);
      vectors++;
      if (obs !== exp_v) begin
        miscompares++;
        $display("FAIL simul_model cyc%0d got %b exp %b", k, obs, exp_v);
      end
      if (fall == 2'b11) begin
        falls++;
        if (first_k < 0) first_k = k;
      end
      if (changed) chg++;
    end
    vectors++;
    if (first_k !== 5 || falls !== 1 || chg !== 1) begin
      miscompares++;
      $display("FAIL simul_fall got edge %0d falls %0d changed %0d exp 5 1 1", first_k, falls, chg);
    end
  endtask

  task automatic test_reset_midcount();
    int first_n = -1;
    step(2'b01);
    step(2'b01);
    #3 reset = 1'b1;
    model_reset();
    #1;
    vectors++;
    if (obs !== 7'b0) begin
      miscompares++;
      $display("FAIL reset_async got %b exp %b", obs, 7'b0);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int n = 1; n <= 9; n++) begin
      step(2'b01);
      vectors++;
      if (obs !== exp_v) begin
        miscompares++;
        $display("FAIL rstmid_model edge%0d got %b exp %b", n, obs, exp_v);
      end
      if (clean[0] && first_n < 0) begin
        first_n = n;
        vectors++;
        if (rise[0] !== 1'b1) begin
          miscompares++;
          $display("FAIL rstmid_rise got %b exp 1", rise[0]);
        end
      end
    end
    vectors++;
    if (first_n !== 6) begin
      miscompares++;
      $display("FAIL rstmid_latency got edge %0d exp edge 6", first_n);
    end
  endtask

  task automatic test_bounce();
    logic [8:0] pat;
    int first_k = -1;
    int rises   = 0;
    pat = 9'b101101111;
    for (int k = 0; k < 10; k++) step(2'b00);
    for (int k = 0; k < 18; k++) begin
      step({1'b0, (k < 9) ? pat[8-k] : 1'b1});
      vectors++;
      if (obs !== exp_v) begin
        miscompares++;
        $display("FAIL bounce_model cyc%0d got %b exp %b", k, obs, exp_v);
      end
      if (rise[0]) begin
        rises++;
        if (first_k < 0) first_k = k;
      end
    end
    vectors++;
    if (first_k !== 10 || rises !== 1) begin
      miscompares++;
      $display("FAIL bounce_rise got edge %0d count %0d exp edge 10 count 1", first_k, rises);
    end
  endtask

  task automatic test_random();
    logic [WIDTH-1:0] v;
    int hold;
    int k = 0;
    while (k < 400) begin
      v    = WIDTH'($urandom_range(0, 3));
      hold = $urandom_range(1, 7);
      for (int h = 0; h < hold; h++) begin
        step(v);
        vectors++;
        if (obs !== exp_v) begin
          miscompares++;
          $display("FAIL random cyc%0d raw=%b got %b exp %b", k, v, obs, exp_v);
        end
        vectors++;
        if ((rise & fall) !== '0) begin
          miscompares++;
          $display("FAIL rise_fall_overlap cyc%0d got %b exp 00", k, rise & fall);
        end
        k++;
      end
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b1;
    raw         = '0;
    model_reset();
    test_reset();
    test_rise_latency();
    test_glitch();
    test_simultaneous();
    test_reset_midcount();
    test_bounce();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
